// File: rtl/ethernet_echo.sv
// Loopback engine: copies each packet from the MAC receive buffer into the
// transmit buffer word by word, commits the send, then releases the receive buffer.
module ethernet_echo #(
    parameter int eth_mtu_p    = 2048,
    parameter int data_width_p = 32,
    localparam int bytes_lp             = data_width_p / 8,
    localparam int lg_bytes_lp          = $clog2(bytes_lp),
    localparam int size_width_lp        = $clog2(((bytes_lp > 1) ? lg_bytes_lp : 1) + 1),
    localparam int addr_width_lp        = $clog2(eth_mtu_p),
    localparam int packet_size_width_lp = $clog2(eth_mtu_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            en_i,

    input  logic                            packet_avail_i,
    input  logic [packet_size_width_lp-1:0] packet_rsize_i,
    output logic                            packet_rvalid_o,
    output logic [addr_width_lp-1:0]        packet_raddr_o,
    output logic [size_width_lp-1:0]        packet_rdata_size_o,
    input  logic [data_width_p-1:0]         packet_rdata_i,
    output logic                            packet_ack_o,

    input  logic                            packet_req_i,
    output logic                            packet_wsize_valid_o,
    output logic [packet_size_width_lp-1:0] packet_wsize_o,
    output logic                            packet_wvalid_o,
    output logic [addr_width_lp-1:0]        packet_waddr_o,
    output logic [data_width_p-1:0]         packet_wdata_o,
    output logic [size_width_lp-1:0]        packet_wdata_size_o,
    output logic                            packet_send_o,

    output logic                            busy_o,
    output logic [15:0]                     echo_count_o,
    output logic [15:0]                     drop_count_o
);

    // One extra bit lets the counter reach N itself for a full-MTU packet.
    localparam int cnt_width_lp = addr_width_lp - lg_bytes_lp + 1;
    localparam logic [packet_size_width_lp-1:0] low_mask_lp = packet_size_width_lp'(bytes_lp - 1);
    localparam logic [size_width_lp-1:0] word_size_lp = size_width_lp'(lg_bytes_lp);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SIZE = 3'd1,
        COPY = 3'd2,
        SEND = 3'd3,
        ACK  = 3'd4
    } state_e;

    state_e                          state_q, state_d;
    logic [packet_size_width_lp-1:0] size_q, size_d;
    logic [cnt_width_lp-1:0]         n_q, n_d;
    logic [cnt_width_lp-1:0]         c_q, c_d;
    logic [15:0]                     echo_q, echo_d;
    logic [15:0]                     drop_q, drop_d;

    logic [packet_size_width_lp-1:0] words_full;
    logic                            round_up;
    logic [cnt_width_lp-1:0]         n_calc;
    logic [cnt_width_lp-1:0]         c_prev;
    logic                            rd_active;
    logic                            wr_active;

    assign words_full = packet_rsize_i >> lg_bytes_lp;
    assign round_up   = |(packet_rsize_i & low_mask_lp);
    assign n_calc     = cnt_width_lp'(words_full) + cnt_width_lp'(round_up);
    assign c_prev     = c_q - cnt_width_lp'(1);

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        n_d     = n_q;
        c_d     = c_q;
        echo_d  = echo_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (en_i && packet_avail_i) begin
                    if (packet_rsize_i == '0) begin
                        drop_d  = drop_q + 16'd1;
                        state_d = ACK;
                    end else if (packet_req_i) begin
                        size_d  = packet_rsize_i;
                        n_d     = n_calc;
                        state_d = SIZE;
                    end
                end
            end
            SIZE: begin
                c_d     = '0;
                state_d = COPY;
            end
            COPY: begin
                if (c_q == n_q) begin
                    state_d = SEND;
                end else begin
                    c_d = c_q + cnt_width_lp'(1);
                end
            end
            SEND: begin
                echo_d  = echo_q + 16'd1;
                state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A reset mid-packet abandons it silently; the pending receive packet is re-echoed later.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            size_q  <= '0;
            n_q     <= '0;
            c_q     <= '0;
            echo_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            n_q     <= n_d;
            c_q     <= c_d;
            echo_q  <= echo_d;
            drop_q  <= drop_d;
        end
    end

    // Reads lead writes by one cycle because read data returns a cycle late.
    assign rd_active = (state_q == COPY) && (c_q != n_q);
    assign wr_active = (state_q == COPY) && (c_q != '0);

    assign packet_rvalid_o      = rd_active;
    assign packet_raddr_o       = rd_active ? (addr_width_lp'(c_q) << lg_bytes_lp) : '0;
    assign packet_rdata_size_o  = rd_active ? word_size_lp : '0;

    assign packet_wvalid_o      = wr_active;
    assign packet_waddr_o       = wr_active ? (addr_width_lp'(c_prev) << lg_bytes_lp) : '0;
    assign packet_wdata_o       = wr_active ? packet_rdata_i : '0;
    assign packet_wdata_size_o  = wr_active ? word_size_lp : '0;

    assign packet_wsize_valid_o = (state_q == SIZE);
    assign packet_wsize_o       = (state_q == SIZE) ? size_q : '0;
    assign packet_send_o        = (state_q == SEND);
    assign packet_ack_o         = (state_q == ACK);
    assign busy_o               = (state_q != IDLE);
    assign echo_count_o         = echo_q;
    assign drop_count_o         = drop_q;

endmodule

// File: tb/tb_ethernet_echo.sv
// Self-checking bench for ethernet_echo: per-cycle comparison of all buffer-side
// outputs against a latency-table model of the echo protocol.
module tb_ethernet_echo;
    localparam int BYTES = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        en_i;
    logic        packet_avail_i;
    logic [11:0] packet_rsize_i;
    logic        packet_rvalid_o;
    logic [10:0] packet_raddr_o;
    logic [1:0]  packet_rdata_size_o;
    logic [31:0] packet_rdata_i;
    logic        packet_ack_o;
    logic        packet_req_i;
    logic        packet_wsize_valid_o;
    logic [11:0] packet_wsize_o;
    logic        packet_wvalid_o;
    logic [10:0] packet_waddr_o;
    logic [31:0] packet_wdata_o;
    logic [1:0]  packet_wdata_size_o;
    logic        packet_send_o;
    logic        busy_o;
    logic [15:0] echo_count_o;
    logic [15:0] drop_count_o;

    always #5 clk_i = ~clk_i;

    ethernet_echo dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .en_i                 (en_i),
        .packet_avail_i       (packet_avail_i),
        .packet_rsize_i       (packet_rsize_i),
        .packet_rvalid_o      (packet_rvalid_o),
        .packet_raddr_o       (packet_raddr_o),
        .packet_rdata_size_o  (packet_rdata_size_o),
        .packet_rdata_i       (packet_rdata_i),
        .packet_ack_o         (packet_ack_o),
        .packet_req_i         (packet_req_i),
        .packet_wsize_valid_o (packet_wsize_valid_o),
        .packet_wsize_o       (packet_wsize_o),
        .packet_wvalid_o      (packet_wvalid_o),
        .packet_waddr_o       (packet_waddr_o),
        .packet_wdata_o       (packet_wdata_o),
        .packet_wdata_size_o  (packet_wdata_size_o),
        .packet_send_o        (packet_send_o),
        .busy_o               (busy_o),
        .echo_count_o         (echo_count_o),
        .drop_count_o         (drop_count_o)
    );

    typedef logic [75:0] vec_t;

    vec_t        obs;
    logic [31:0] rx_words [512];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_echo = '0;
    logic [15:0] exp_drop = '0;

    assign obs = {packet_wsize_valid_o, packet_wsize_o, packet_rvalid_o, packet_raddr_o,
                  packet_rdata_size_o, packet_wvalid_o, packet_waddr_o, packet_wdata_o,
                  packet_wdata_size_o, packet_send_o, packet_ack_o, busy_o};

    // Expected outputs k cycles after the accept cycle, from the protocol latency table.
    function automatic vec_t model(input int k, input int size);
        int          n   = (size + BYTES - 1) / BYTES;
        logic        wsv = 1'b0;
        logic [11:0] ws  = '0;
        logic        rv  = 1'b0;
        logic [10:0] ra  = '0;
        logic [1:0]  rs  = '0;
        logic        wv  = 1'b0;
        logic [10:0] wa  = '0;
        logic [31:0] wd  = '0;
        logic [1:0]  wds = '0;
        logic        snd = 1'b0;
        logic        ack = 1'b0;
        logic        bsy = 1'b0;
        if (size == 0) begin
            ack = (k == 1);
            bsy = (k == 1);
        end else begin
            bsy = (k >= 1) && (k <= n + 4);
            if (k == 1) begin
                wsv = 1'b1;
                ws  = 12'(size);
            end
            if (k >= 2 && k <= n + 1) begin
                rv = 1'b1;
                ra = 11'((k - 2) * BYTES);
                rs = 2'd2;
            end
            if (k >= 3 && k <= n + 2) begin
                wv  = 1'b1;
                wa  = 11'((k - 3) * BYTES);
                wd  = rx_words[k - 3];
                wds = 2'd2;
            end
            snd = (k == n + 3);
            ack = (k == n + 4);
        end
        return {wsv, ws, rv, ra, rs, wv, wa, wd, wds, snd, ack, bsy};
    endfunction

    // Offers one packet at the current negedge and checks every cycle until IDLE again.
    // abort_k > 0 asserts reset after that cycle's check instead of completing.
    task automatic echo_pkt(input int size, input int req_delay, input bit fresh,
                            input int abort_k, input string name);
        int   n    = (size + BYTES - 1) / BYTES;
        int   last = (size == 0) ? 2 : n + 5;
        vec_t expv;
        if (fresh) begin
            for (int i = 0; i < 512; i++) rx_words[i] = $urandom;
        end
        en_i           = 1'b1;
        packet_avail_i = 1'b1;
        packet_rsize_i = 12'(size);
        if (size == 0) packet_req_i = 1'($urandom_range(0, 1));
        else           packet_req_i = (req_delay == 0);
        for (int d = 1; d <= req_delay; d++) begin
            @(negedge clk_i);
            n_cmp++;
            if (obs !== '0) begin
                n_bad++;
                $display("FAIL %s req_wait cycle %0d: got %h want 0", name, d, obs);
            end
        end
        packet_req_i = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk_i);
            expv = model(k, size);
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got %h want %h", name, k, obs, expv);
            end
            if (k == abort_k) begin
                reset_i = 1'b1;
                for (int r = 1; r <= 2; r++) begin
                    @(negedge clk_i);
                    n_cmp++;
                    if (obs !== '0 || echo_count_o !== 16'd0 || drop_count_o !== 16'd0) begin
                        n_bad++;
                        $display("FAIL %s reset cycle %0d: got %h/%h/%h want 0/0/0",
                                 name, r, obs, echo_count_o, drop_count_o);
                    end
                end
                exp_echo = '0;
                exp_drop = '0;
                reset_i  = 1'b0;
                return;
            end
            if (packet_rvalid_o) packet_rdata_i = rx_words[packet_raddr_o[10:2]];
            else                 packet_rdata_i = $urandom;
            if (expv[1]) packet_avail_i = 1'b0;
        end
        if (size == 0) exp_drop = exp_drop + 16'd1;
        else           exp_echo = exp_echo + 16'd1;
        n_cmp++;
        if (echo_count_o !== exp_echo || drop_count_o !== exp_drop) begin
            n_bad++;
            $display("FAIL %s counters: got echo=%0d drop=%0d want echo=%0d drop=%0d",
                     name, echo_count_o, drop_count_o, exp_echo, exp_drop);
        end
        $display("txn %s size=%0d words=%0d echo=%0d drop=%0d", name, size, n,
                 echo_count_o, drop_count_o);
    endtask

    task automatic test_reset;
        reset_i        = 1'b1;
        en_i           = 1'b0;
        packet_avail_i = 1'b0;
        packet_req_i   = 1'b0;
        packet_rsize_i = '0;
        packet_rdata_i = '0;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (obs !== '0 || echo_count_o !== 16'd0 || drop_count_o !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h/%h/%h want 0/0/0", obs, echo_count_o, drop_count_o);
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (obs !== '0) begin
            n_bad++;
            $display("FAIL reset_release: got %h want 0", obs);
        end
        $display("txn reset done");
    endtask

    task automatic test_basic;
        echo_pkt(64, 0, 1'b1, 0, "pkt64");
        echo_pkt(61, 0, 1'b1, 0, "pkt61");
    endtask

    task automatic test_zero_len;
        echo_pkt(0, 0, 1'b1, 0, "zero_len");
    endtask

    task automatic test_req_wait;
        echo_pkt(37, 10, 1'b1, 0, "req_wait");
    endtask

    task automatic test_disabled;
        en_i           = 1'b0;
        packet_avail_i = 1'b1;
        packet_req_i   = 1'b1;
        packet_rsize_i = 12'd100;
        for (int d = 1; d <= 10; d++) begin
            @(negedge clk_i);
            n_cmp++;
            if (obs !== '0) begin
                n_bad++;
                $display("FAIL disabled cycle %0d: got %h want 0", d, obs);
            end
        end
        n_cmp++;
        if (echo_count_o !== exp_echo || drop_count_o !== exp_drop) begin
            n_bad++;
            $display("FAIL disabled counters: got %0d/%0d want %0d/%0d",
                     echo_count_o, drop_count_o, exp_echo, exp_drop);
        end
        packet_avail_i = 1'b0;
        en_i           = 1'b1;
        $display("txn disabled idle checked");
    endtask

    task automatic test_reset_mid_copy;
        echo_pkt(64, 0, 1'b1, 7, "abort64");
        echo_pkt(64, 0, 1'b0, 0, "reecho64");
    endtask

    task automatic test_max_size;
        echo_pkt(2048, 0, 1'b1, 0, "mtu2048");
    endtask

    task automatic test_back_to_back;
        int size;
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0:       size = 0;
                1:       size = $urandom_range(1, 8);
                2:       size = $urandom_range(2040, 2048);
                default: size = $urandom_range(1, 300);
            endcase
            echo_pkt(size, 0, 1'b1, 0, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_req_wait();
        test_disabled();
        test_reset_mid_copy();
        test_max_size();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
